// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and constants for the load/store unit.
//   lsu_state_e      : FSM states (IDLE, RD, WR, RESP)
//   SIZE_B/H/W       : request size encodings (2'b11 is normalised to word)
//   lsu_misaligned() : alignment predicate used when LSU_ALIGN_CHECK_EN is defined
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RD   = 2'b01,
        WR   = 2'b10,
        RESP = 2'b11
    } lsu_state_e;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    // Halfwords need addr[0] clear, words need addr[1:0] clear; bytes never misalign.
    function automatic logic lsu_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        bad = 1'b0;
        case (size)
            SIZE_B:  bad = 1'b0;
            SIZE_H:  bad = addr_lo[0];
            default: bad = (addr_lo != 2'b00);
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// lsu_byte_lane: purely combinational lane logic for the load/store unit.
//   size      in  2  : request size (SIZE_B / SIZE_H / anything else = word)
//   is_unsigned in 1 : zero-extend loads instead of sign-extending
//   rd_word   in 32  : word read from memory (load) or merge buffer (store)
//   st_data   in 32  : LSB-aligned store data
//   ld_value  out 32 : extended load value taken from the low lane of rd_word
//   st_word   out 32 : full word to write back (low lane replaced for sub-word)
module lsu_byte_lane
    import lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] rd_word,
    input  logic [31:0] st_data,
    output logic [31:0] ld_value,
    output logic [31:0] st_word
);

    // Memory returns the addressed byte in bits [7:0], so the low lane is always the target.
    always_comb begin
        ld_value = rd_word;
        st_word  = st_data;
        case (size)
            SIZE_B: begin
                ld_value = is_unsigned ? {24'h000000, rd_word[7:0]}
                                       : {{24{rd_word[7]}}, rd_word[7:0]};
                st_word  = {rd_word[31:8], st_data[7:0]};
            end
            SIZE_H: begin
                ld_value = is_unsigned ? {16'h0000, rd_word[15:0]}
                                       : {{16{rd_word[15]}}, rd_word[15:0]};
                st_word  = {rd_word[31:16], st_data[15:0]};
            end
            default: begin
                ld_value = rd_word;
                st_word  = st_data;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: multi-cycle byte/halfword/word load/store initiator.
// Sub-word stores are done as read-modify-write because memory writes whole 4-byte groups.
// Optional feature macro: LSU_ALIGN_CHECK_EN (reject misaligned halfword/word requests).
// Ports:
//   clk, rst                         : clock, synchronous active-high reset
//   req_valid/req_ready              : request handshake (ready only in IDLE)
//   req_we, req_size, req_unsigned   : store flag, size (11 = word), zero-extend loads
//   req_addr, req_wdata              : byte address, LSB-aligned store data
//   resp_valid, resp_rdata, resp_err : one-cycle completion pulse, load data, misalign error
//   mem_adr, mem_wd, mem_we, mem_rd  : memory address, write data, write enable, read data
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_adr,
    output logic [DATA_W-1:0] mem_wd,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rd
);

    lsu_state_e        state;
    logic [ADDR_W-1:0] lat_addr;
    logic [1:0]        lat_size;
    logic              lat_we;
    logic              lat_uns;
    logic [DATA_W-1:0] lat_wdata;
    logic [DATA_W-1:0] merge_buf;

    logic [1:0]        req_size_n;
    logic [DATA_W-1:0] lane_rd;
    logic [DATA_W-1:0] lane_ld;
    logic [DATA_W-1:0] lane_st;

    // Size 2'b11 behaves as a word everywhere, so fold it at the input.
    assign req_size_n = (req_size == 2'b11) ? SIZE_W : req_size;

    // The lane reads memory during RD (load extend) and the merge buffer during WR.
    assign lane_rd = (state == WR) ? merge_buf : mem_rd;

    lsu_byte_lane u_lane (
        .size        (lat_size),
        .is_unsigned (lat_uns),
        .rd_word     (lane_rd),
        .st_data     (lat_wdata),
        .ld_value    (lane_ld),
        .st_word     (lane_st)
    );

    assign req_ready = (state == IDLE);
    assign mem_adr   = ((state == RD) || (state == WR)) ? lat_addr : '0;
    assign mem_wd    = (state == WR) ? lane_st : '0;
    // Reset gates the strobe directly so a write caught mid-flight never reaches memory.
    assign mem_we    = (state == WR) && !rst;

`ifdef LSU_ALIGN_CHECK_EN
    logic resp_err_q;
    assign resp_err = resp_err_q;
`else
    assign resp_err = 1'b0;
`endif

    // Main FSM: request latch, read/merge, write, and registered response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            lat_addr   <= '0;
            lat_size   <= SIZE_B;
            lat_we     <= 1'b0;
            lat_uns    <= 1'b0;
            lat_wdata  <= '0;
            merge_buf  <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
`ifdef LSU_ALIGN_CHECK_EN
            resp_err_q <= 1'b0;
`endif
        end else begin
            resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        lat_addr  <= req_addr;
                        lat_size  <= req_size_n;
                        lat_we    <= req_we;
                        lat_uns   <= req_unsigned;
                        lat_wdata <= req_wdata;
`ifdef LSU_ALIGN_CHECK_EN
                        if (lsu_misaligned(req_size_n, req_addr[1:0])) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_rdata <= '0;
                            resp_err_q <= 1'b1;
                        end else
`endif
                        if (req_we && (req_size_n == SIZE_W)) begin
                            state <= WR;
                        end else begin
                            state <= RD;
                        end
                    end
                end
                RD: begin
                    if (lat_we) begin
                        merge_buf <= mem_rd;
                        state     <= WR;
                    end else begin
                        resp_rdata <= lane_ld;
                        resp_valid <= 1'b1;
`ifdef LSU_ALIGN_CHECK_EN
                        resp_err_q <= 1'b0;
`endif
                        state      <= RESP;
                    end
                end
                WR: begin
                    resp_rdata <= '0;
                    resp_valid <= 1'b1;
`ifdef LSU_ALIGN_CHECK_EN
                    resp_err_q <= 1'b0;
`endif
                    state      <= RESP;
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed self-checking bench for load_store_unit with a byte memory model.
// Expected responses are queued when a request is issued and popped when the response arrives.
module tb_load_store_unit;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        preload;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_adr;
    logic [31:0] mem_wd;
    logic        mem_we;
    logic [31:0] mem_rd;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          wes;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_adr      (mem_adr),
        .mem_wd       (mem_wd),
        .mem_we       (mem_we),
        .mem_rd       (mem_rd)
    );

    // Byte-addressed memory model, 256 bytes, wrapping; combinational read, word write.
    logic [7:0] mem [0:255];
    logic [7:0] ma;
    assign ma     = mem_adr[7:0];
    assign mem_rd = {mem[8'(ma + 8'd3)], mem[8'(ma + 8'd2)], mem[8'(ma + 8'd1)], mem[ma]};

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
            mem[8'h10] <= 8'hBB; mem[8'h11] <= 8'hAA; mem[8'h12] <= 8'h99; mem[8'h13] <= 8'h88;
            mem[8'h14] <= 8'h44; mem[8'h15] <= 8'h33; mem[8'h16] <= 8'h22; mem[8'h17] <= 8'h11;
        end else if (mem_we) begin
            mem[ma]               <= mem_wd[7:0];
            mem[8'(ma + 8'd1)]    <= mem_wd[15:8];
            mem[8'(ma + 8'd2)]    <= mem_wd[23:16];
            mem[8'(ma + 8'd3)]    <= mem_wd[31:24];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request from a negedge and check its response; returns at the negedge after RESP.
    task automatic issue(input string tag, input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_err,
                         input int exp_lat, input int exp_wes);
        exp_t        e;
        int          n;
        int          lat;
        int          wes;
        logic        got;
        logic [31:0] rd;
        logic        er;
        e.rdata = exp_rdata; e.err = exp_err; e.lat = exp_lat; e.wes = exp_wes;
        sb.push_back(e);
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, " ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 99; wes = 0; got = 1'b0; rd = '0; er = 1'b0;
        for (int c = 1; c <= 10 && !got; c++) begin
            @(negedge clk);
            if (mem_we) wes++;
            if (resp_valid) begin
                got = 1'b1; lat = c; rd = resp_rdata; er = resp_err;
            end
        end
        e = sb.pop_front();
        check({tag, " latency"}, 32'(lat), 32'(e.lat));
        check({tag, " rdata"},   rd,       e.rdata);
        check({tag, " err"},     32'(er),  32'(e.err));
        check({tag, " we_cnt"},  32'(wes), 32'(e.wes));
        @(negedge clk);
        check({tag, " pulse"},   32'(resp_valid), 32'd0);
        check({tag, " hold"},    resp_rdata,      e.rdata);
        check({tag, " idle_adr"}, mem_adr,        32'd0);
    endtask

    initial begin
        rst = 1'b1; preload = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_size = SIZE_B; req_unsigned = 1'b0;
        req_addr = '0; req_wdata = '0;
        repeat (3) @(negedge clk);
        check("rst ready",  32'(req_ready),  32'd1);
        check("rst rvalid", 32'(resp_valid), 32'd0);
        check("rst rdata",  resp_rdata,      32'd0);
        check("rst err",    32'(resp_err),   32'd0);
        check("rst we",     32'(mem_we),     32'd0);
        check("rst adr",    mem_adr,         32'd0);
        check("rst wd",     mem_wd,          32'd0);
        rst = 1'b0; preload = 1'b0;
        @(negedge clk);

        issue("LB 10",  1'b0, SIZE_B, 1'b0, 32'h10, 32'h0, 32'hFFFFFFBB, 1'b0, 2, 0);
        issue("LBU 10", 1'b0, SIZE_B, 1'b1, 32'h10, 32'h0, 32'h000000BB, 1'b0, 2, 0);
        issue("LH 12",  1'b0, SIZE_H, 1'b0, 32'h12, 32'h0, 32'hFFFF8899, 1'b0, 2, 0);
        issue("LW 10",  1'b0, SIZE_W, 1'b0, 32'h10, 32'h0, 32'h8899AABB, 1'b0, 2, 0);
`ifdef LSU_ALIGN_CHECK_EN
        issue("LW 12",  1'b0, SIZE_W, 1'b0, 32'h12, 32'h0, 32'h00000000, 1'b1, 1, 0);
`else
        issue("LW 12",  1'b0, SIZE_W, 1'b0, 32'h12, 32'h0, 32'h33448899, 1'b0, 2, 0);
`endif

        // SH 0x10 with reset pulsed during the write cycle: no write, no response.
        req_valid = 1'b1; req_we = 1'b1; req_size = SIZE_H; req_unsigned = 1'b0;
        req_addr = 32'h10; req_wdata = 32'h0000FFFF;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("SH rst in_wr", 32'(mem_we), 32'd1);
        rst = 1'b1;
        #1 check("SH rst we_gated", 32'(mem_we), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        check("SH rst ready",  32'(req_ready),  32'd1);
        check("SH rst rvalid", 32'(resp_valid), 32'd0);
        @(negedge clk);
        check("SH rst norsp",  32'(resp_valid), 32'd0);
        issue("LW 10 post", 1'b0, SIZE_W, 1'b0, 32'h10, 32'h0, 32'h8899AABB, 1'b0, 2, 0);

        issue("SB 11",  1'b1, SIZE_B, 1'b0, 32'h11, 32'h12345655, 32'h0, 1'b0, 3, 1);
        issue("LW 10b", 1'b0, SIZE_W, 1'b0, 32'h10, 32'h0, 32'h889955BB, 1'b0, 2, 0);
        issue("LW 14",  1'b0, SIZE_W, 1'b0, 32'h14, 32'h0, 32'h11223344, 1'b0, 2, 0);
        issue("SW 14",  1'b1, SIZE_W, 1'b0, 32'h14, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1);
        issue("LHU 16", 1'b0, SIZE_H, 1'b1, 32'h16, 32'h0, 32'h0000DEAD, 1'b0, 2, 0);
        issue("SH 16",  1'b1, SIZE_H, 1'b0, 32'h16, 32'h1234CAFE, 32'h0, 1'b0, 3, 1);
        issue("LW 14b", 1'b0, SIZE_W, 1'b0, 32'h14, 32'h0, 32'hCAFEBEEF, 1'b0, 2, 0);
        issue("LB 17",  1'b0, SIZE_B, 1'b0, 32'h17, 32'h0, 32'hFFFFFFCA, 1'b0, 2, 0);
        issue("LBU 16", 1'b0, SIZE_B, 1'b1, 32'h16, 32'h0, 32'h000000FE, 1'b0, 2, 0);
        issue("L11 14", 1'b0, 2'b11,  1'b0, 32'h14, 32'h0, 32'hCAFEBEEF, 1'b0, 2, 0);
        issue("LW 18",  1'b0, SIZE_W, 1'b0, 32'h18, 32'h0, 32'h00000000, 1'b0, 2, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
